// File: rtl/rand_range_sampler.sv
// Bounded random-integer sampler: turns an 8-bit LFSR word into a uniform value in 0..N-1
// by mask-and-reject. Also reseeds the LFSR when it locks up at zero.
module rand_range_sampler #(
    parameter int unsigned MAX_TRIES   = 16,
    parameter int unsigned LOCK_CYCLES = 2,
    parameter logic [7:0]  SEED_INIT   = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rnd,
    input  logic [7:0] range_max,
    input  logic       req,
    input  logic       ack,
    output logic       busy,
    output logic       valid,
    output logic [7:0] value,
    output logic       fallback,
    output logic       seed_val,
    output logic [7:0] seed,
    output logic [1:0] o_dbg_state
);

    // Handshake: req is a level accepted only in IDLE; the result is presented with valid
    // (value/fallback stable while valid=1) and retired by ack=1 at an edge in DONE.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SAMPLE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [7:0] TRY_LAST  = 8'(MAX_TRIES - 1);
    localparam logic [3:0] LOCK_LAST = 4'(LOCK_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [8:0] r_n;
    logic [7:0] r_mask;
    logic [7:0] r_tries;
    logic [7:0] r_value;
    logic       r_fallback;
    logic [3:0] r_zero_cnt;
    logic       r_seed_val;

    logic [8:0] w_n_new;
    logic [7:0] w_m;
    logic [7:0] w_m1;
    logic [7:0] w_m2;
    logic [7:0] w_mask_new;
    logic [7:0] w_cand;
    logic       w_cand_ok;
    logic       w_load;
    logic       w_done_ok;
    logic       w_done_fb;
    logic       w_try_inc;

    // range_max==0 stands for 256; the decrement wraps to FF which gives the full mask.
    assign w_n_new    = (range_max == 8'd0) ? 9'd256 : {1'b0, range_max};
    assign w_m        = range_max - 8'd1;
    assign w_m1       = w_m | (w_m >> 1);
    assign w_m2       = w_m1 | (w_m1 >> 2);
    assign w_mask_new = w_m2 | (w_m2 >> 4);

    assign w_cand    = rnd & r_mask;
    assign w_cand_ok = ({1'b0, w_cand} < r_n);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_done_ok   = 1'b0;
        w_done_fb   = 1'b0;
        w_try_inc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_state_nxt = S_SAMPLE;
                    w_load      = 1'b1;
                end
            end
            S_SAMPLE: begin
                // A zero word is the LFSR lock-up value, not a sample; skip it.
                if (rnd != 8'd0) begin
                    if (w_cand_ok) begin
                        w_done_ok   = 1'b1;
                        w_state_nxt = S_DONE;
                    end else if (r_tries == TRY_LAST) begin
                        w_done_fb   = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_try_inc = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_n        <= 9'd0;
            r_mask     <= 8'd0;
            r_tries    <= 8'd0;
            r_value    <= 8'd0;
            r_fallback <= 1'b0;
        end else begin
            if (w_load) begin
                r_n        <= w_n_new;
                r_mask     <= w_mask_new;
                r_tries    <= 8'd0;
                r_fallback <= 1'b0;
            end
            if (w_done_ok) begin
                r_value    <= w_cand;
                r_fallback <= 1'b0;
            end
            // mask < 2N, so a rejected candidate minus N always lands in range.
            if (w_done_fb) begin
                r_value    <= w_cand - r_n[7:0];
                r_fallback <= 1'b1;
            end
            if (w_try_inc) begin
                r_tries <= r_tries + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_zero_cnt <= 4'd0;
            r_seed_val <= 1'b0;
        end else if (rnd == 8'd0) begin
            if (r_zero_cnt == LOCK_LAST) begin
                r_zero_cnt <= 4'd0;
                r_seed_val <= 1'b1;
            end else begin
                r_zero_cnt <= r_zero_cnt + 4'd1;
                r_seed_val <= 1'b0;
            end
        end else begin
            r_zero_cnt <= 4'd0;
            r_seed_val <= 1'b0;
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign valid       = (r_state == S_DONE);
    assign value       = r_value;
    assign fallback    = r_fallback;
    assign seed_val    = r_seed_val;
    assign seed        = SEED_INIT;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rand_range_sampler.sv
// Directed bench for rand_range_sampler (MAX_TRIES=4, LOCK_CYCLES=2) with a small
// behavioural Galois LFSR for the live-hookup recovery scenario.
module tb_rand_range_sampler;

    logic       clk;
    logic       rst;
    logic [7:0] rnd;
    logic [7:0] rnd_drv;
    logic [7:0] range_max;
    logic       req;
    logic       ack;
    logic       busy;
    logic       valid;
    logic [7:0] value;
    logic       fallback;
    logic       seed_val;
    logic [7:0] seed;
    logic [1:0] o_dbg_state;

    logic       use_lfsr;
    logic [7:0] lfsr;

    int n_cmp;
    int n_err;

    rand_range_sampler #(
        .MAX_TRIES  (4),
        .LOCK_CYCLES(2),
        .SEED_INIT  (8'hA5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rnd        (rnd),
        .range_max  (range_max),
        .req        (req),
        .ack        (ack),
        .busy       (busy),
        .valid      (valid),
        .value      (value),
        .fallback   (fallback),
        .seed_val   (seed_val),
        .seed       (seed),
        .o_dbg_state(o_dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // LFSR stand-in: reset-zero while unused, loads seed on seed_val, else x^8+x^6+x^5+x^4+1.
    always @(posedge clk) begin
        if (!use_lfsr) lfsr <= 8'd0;
        else if (seed_val) lfsr <= seed;
        else lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 8'hB8 : 8'h00);
    end

    assign rnd = use_lfsr ? lfsr : rnd_drv;

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // scoreboard check
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int k;
        k = 0;
        while (valid !== 1'b1 && k < budget) begin
            step();
            k++;
        end
        chk(tag, {7'd0, valid}, 8'd1);
    endtask

    int fb_cnt;
    int seen_pulse;

    initial begin
        n_cmp = 0; n_err = 0;
        use_lfsr = 1'b0; rst = 1'b0; rnd_drv = 8'h01; range_max = 8'd0;
        req = 1'b0; ack = 1'b0;

        // reset state
        steps(2);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_valid", {7'd0, valid}, 8'd0);
        chk("rst_value", value, 8'd0);
        chk("rst_fallback", {7'd0, fallback}, 8'd0);
        chk("rst_seed_val", {7'd0, seed_val}, 8'd0);
        chk("rst_seed", seed, 8'hA5);
        rst = 1'b1;
        step();

        // 1: N=6, one rejection (0x0E&7=6) then accept (0x13&7=3)
        range_max = 8'd6; rnd_drv = 8'h0E; req = 1'b1;
        step();
        req = 1'b0;
        chk("t1_busy", {7'd0, busy}, 8'd1);
        chk("t1_valid_early", {7'd0, valid}, 8'd0);
        step();
        chk("t1_valid_after_reject", {7'd0, valid}, 8'd0);
        rnd_drv = 8'h13;
        step();
        chk("t1_valid", {7'd0, valid}, 8'd1);
        chk("t1_value", value, 8'd3);
        chk("t1_fallback", {7'd0, fallback}, 8'd0);
        range_max = 8'd9;
        for (int i = 0; i < 5; i++) begin
            rnd_drv = 8'(i * 37 + 1);
            step();
            chk("t1_hold_valid", {7'd0, valid}, 8'd1);
            chk("t1_hold_value", value, 8'd3);
        end
        chk("t1_seed_val_quiet", {7'd0, seed_val}, 8'd0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("t1_ack_valid", {7'd0, valid}, 8'd0);
        chk("t1_ack_busy", {7'd0, busy}, 8'd0);

        // 2: N=5, rnd=7 always rejected -> fallback 7-5=2 after 4 samples
        range_max = 8'd5; rnd_drv = 8'h07; req = 1'b1;
        step();
        req = 1'b0;
        steps(3);
        chk("t2_valid_early", {7'd0, valid}, 8'd0);
        step();
        chk("t2_valid", {7'd0, valid}, 8'd1);
        chk("t2_value", value, 8'd2);
        chk("t2_fallback", {7'd0, fallback}, 8'd1);

        // back-to-back ack+req: IDLE on this edge, accepted on the next
        ack = 1'b1; req = 1'b1; range_max = 8'd8; rnd_drv = 8'h0C;
        step();
        chk("b2b_idle", {7'd0, busy}, 8'd0);
        ack = 1'b0;
        step();
        req = 1'b0;
        chk("b2b_accept", {7'd0, busy}, 8'd1);
        step();
        chk("b2b_valid", {7'd0, valid}, 8'd1);
        chk("b2b_value", value, 8'd4);
        chk("b2b_fallback", {7'd0, fallback}, 8'd0);
        ack = 1'b1;
        step();
        ack = 1'b0;

        // 3: zeros pulse seed_val every 2nd cycle and do not count as tries
        range_max = 8'd5; rnd_drv = 8'h00; req = 1'b1;
        step();
        req = 1'b0;
        chk("t3_pulse0_low", {7'd0, seed_val}, 8'd0);
        step();
        chk("t3_pulse1", {7'd0, seed_val}, 8'd1);
        chk("t3_seed", seed, 8'hA5);
        chk("t3_busy", {7'd0, busy}, 8'd1);
        step();
        chk("t3_pulse1_end", {7'd0, seed_val}, 8'd0);
        step();
        chk("t3_pulse2", {7'd0, seed_val}, 8'd1);
        rnd_drv = 8'h07;
        steps(3);
        chk("t3_no_fallback_yet", {7'd0, valid}, 8'd0);
        chk("t3_seed_val_clear", {7'd0, seed_val}, 8'd0);
        rnd_drv = 8'h04;
        step();
        chk("t3_valid", {7'd0, valid}, 8'd1);
        chk("t3_value", value, 8'd4);
        chk("t3_fallback", {7'd0, fallback}, 8'd0);
        ack = 1'b1;
        step();
        ack = 1'b0;

        // 4: N=0 means 256; N=1 always yields 0
        range_max = 8'd0; rnd_drv = 8'hC3; req = 1'b1;
        step();
        req = 1'b0;
        step();
        chk("t4_n256_valid", {7'd0, valid}, 8'd1);
        chk("t4_n256_value", value, 8'hC3);
        ack = 1'b1;
        step();
        ack = 1'b0;
        range_max = 8'd1; rnd_drv = 8'hFF; req = 1'b1;
        step();
        req = 1'b0;
        step();
        chk("t4_n1_valid", {7'd0, valid}, 8'd1);
        chk("t4_n1_value", value, 8'd0);
        chk("t4_n1_fallback", {7'd0, fallback}, 8'd0);
        ack = 1'b1;
        step();
        ack = 1'b0;

        // 5: live LFSR stuck at zero, recovered by seed_val, then 20 requests with N=6
        use_lfsr = 1'b1;
        seen_pulse = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (seed_val === 1'b1) seen_pulse = 1;
        end
        chk("t5_reseed_pulse", 8'(seen_pulse), 8'd1);
        step();
        chk("t5_lfsr_live", {7'd0, (rnd != 8'd0)}, 8'd1);
        fb_cnt = 0;
        range_max = 8'd6;
        for (int r = 0; r < 20; r++) begin
            req = 1'b1;
            step();
            req = 1'b0;
            wait_valid(40, "t5_valid");
            chk("t5_in_range", {7'd0, (value < 8'd6)}, 8'd1);
            if (fallback === 1'b1) fb_cnt++;
            ack = 1'b1;
            step();
            ack = 1'b0;
        end
        chk("t5_few_fallbacks", {7'd0, (fb_cnt < 5)}, 8'd1);

        // 6: async reset in SAMPLE while seed_val is high
        use_lfsr = 1'b0; rnd_drv = 8'h00; range_max = 8'd8; req = 1'b1;
        step();
        req = 1'b0;
        step();
        chk("t6_pre_seed_val", {7'd0, seed_val}, 8'd1);
        chk("t6_pre_busy", {7'd0, busy}, 8'd1);
        #2 rst = 1'b0;
        #1;
        chk("t6_busy_drop", {7'd0, busy}, 8'd0);
        chk("t6_valid_drop", {7'd0, valid}, 8'd0);
        chk("t6_seed_val_drop", {7'd0, seed_val}, 8'd0);
        rnd_drv = 8'h05;
        steps(2);
        rst = 1'b1;
        step();
        chk("t6_no_stale_valid", {7'd0, valid}, 8'd0);
        chk("t6_idle", {7'd0, busy}, 8'd0);
        req = 1'b1;
        step();
        req = 1'b0;
        chk("t6_accept", {7'd0, busy}, 8'd1);
        step();
        chk("t6_valid", {7'd0, valid}, 8'd1);
        chk("t6_value", value, 8'd5);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
